// File: rtl/or_gate_pkg.sv
// -----------------------------------------------------------------------------
// or_gate_pkg
//   Shared defaults for the switch-to-LED OR block and its debounce
//   sub-module, plus a helper that sizes the debounce counter.
//
//   Contents:
//     DEFAULT_SYNC_STAGES      synchronizer depth per switch input (>= 2)
//     DEFAULT_DEBOUNCE_CYCLES  stable samples needed to change a level (>= 1)
//     DEFAULT_CNT_W            width of the c_db rising-edge counter
//     debounce_cnt_w()         counter width able to hold 0 .. cycles-1
// -----------------------------------------------------------------------------
package or_gate_pkg;

  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_CNT_W           = 8;

  // The debounce counter clears on the cycle it would reach `cycles`, so it
  // only ever holds 0 .. cycles-1. Keep at least one bit so a
  // DEBOUNCE_CYCLES of 1 still elaborates a legal vector.
  function automatic int debounce_cnt_w(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage : or_gate_pkg

// File: rtl/or_gate_switch_debounce.sv
// -----------------------------------------------------------------------------
// switch_debounce
//   Brings one asynchronous switch input into the clk domain through a
//   SYNC_STAGES-deep flop chain, then filters it: the debounced level only
//   changes once the synchronized sample has disagreed with it for
//   DEBOUNCE_CYCLES consecutive clocks.
//
//   Ports:
//     clk   in   system clock, rising edge
//     rst   in   asynchronous, active-high reset (clears chain, counter, level)
//     din   in   raw switch level
//     dout  out  debounced, registered level
//
//   Latency from a din change to dout: SYNC_STAGES + DEBOUNCE_CYCLES clocks.
// -----------------------------------------------------------------------------
module switch_debounce
  import or_gate_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int            CW       = debounce_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q,  cnt_d;
  logic                   lvl_q,  lvl_d;
  logic                   sample;

  // Oldest stage of the chain is the only one safe to use as data.
  assign sample = sync_q[SYNC_STAGES-1];

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    cnt_d  = '0;
    lvl_d  = lvl_q;

    // The counter runs only while the sample disagrees with the level; any
    // agreeing sample (a glitch ending) drops it back to zero. On the clock
    // where the count would reach DEBOUNCE_CYCLES the level flips and the
    // counter restarts from zero.
    if (sample != lvl_q) begin
      if (cnt_q == CNT_LAST) begin
        lvl_d = sample;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      lvl_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
    end
  end

  assign dout = lvl_q;

endmodule : switch_debounce

// File: rtl/or_gate.sv
// -----------------------------------------------------------------------------
// or_gate
//   Two-input OR between the lab board switches and an LED. The LED path c is
//   purely combinational and ignores clk and rst. Alongside it the block
//   provides debounced copies of each switch, a registered OR of those, and a
//   wrapping count of rising edges of that registered OR for activity
//   monitoring.
//
//   Ports:
//     clk       in   system clock, rising edge
//     rst       in   asynchronous, active-high reset
//     a, b      in   raw switch levels
//     c         out  a | b, zero latency
//     a_db      out  debounced level of a
//     b_db      out  debounced level of b
//     c_db      out  a_db | b_db, registered one clock later
//     rise_cnt  out  count of c_db 0->1 transitions, modulo 2**CNT_W
// -----------------------------------------------------------------------------
module or_gate
  import or_gate_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  output logic             c,
  output logic             a_db,
  output logic             b_db,
  output logic             c_db,
  output logic [CNT_W-1:0] rise_cnt
);

  logic             c_db_q,     c_db_d;
  logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d;

  // Direct LED drive: must work with the clock stopped and during reset, and
  // must let an X on either switch show through.
  assign c = a | b;

  switch_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_db_a (
    .clk  (clk),
    .rst  (rst),
    .din  (a),
    .dout (a_db)
  );

  switch_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_db_b (
    .clk  (clk),
    .rst  (rst),
    .din  (b),
    .dout (b_db)
  );

  always_comb begin
    c_db_d     = a_db | b_db;
    rise_cnt_d = rise_cnt_q;
    // Count on the same edge that c_db goes 0->1. A 1->1 handover (one
    // switch releasing while the other holds) is not an edge; the counter
    // wraps naturally at 2**CNT_W.
    if (c_db_d && !c_db_q) begin
      rise_cnt_d = rise_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_db_q     <= 1'b0;
      rise_cnt_q <= '0;
    end else begin
      c_db_q     <= c_db_d;
      rise_cnt_q <= rise_cnt_d;
    end
  end

  assign c_db     = c_db_q;
  assign rise_cnt = rise_cnt_q;

endmodule : or_gate

// File: tb/tb_or_gate.sv
// -----------------------------------------------------------------------------
// tb_or_gate
//   Self-checking bench for or_gate. Two instances share the same stimulus:
//   one with default parameters and one with CNT_W=2 for the wrap behaviour.
//   Outputs are compared each clock against a reference model that works on
//   the sampled-input history: the debounced level flips when the last
//   DEBOUNCE_CYCLES synchronizer outputs all disagree with it.
// -----------------------------------------------------------------------------
module tb_or_gate;

  localparam int S = 2;  // synchronizer depth
  localparam int D = 4;  // debounce cycles

  logic       clk    = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst;
  logic       a, b;

  logic       c,  a_db,  b_db,  c_db;
  logic [7:0] rise_cnt;
  logic       c2, a_db2, b_db2, c_db2;
  logic [1:0] rise_cnt2;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  bit hist[2][$];   // raw input values captured at each edge since reset
  bit samp[2][$];   // synchronizer output seen by the debouncer at each edge
  bit lvl[2];       // debounced levels
  bit c_db_m;
  int rise_m;

  or_gate u_dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .c        (c),
    .a_db     (a_db),
    .b_db     (b_db),
    .c_db     (c_db),
    .rise_cnt (rise_cnt)
  );

  or_gate #(.CNT_W(2)) u_dut_w2 (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .c        (c2),
    .a_db     (a_db2),
    .b_db     (b_db2),
    .c_db     (c_db2),
    .rise_cnt (rise_cnt2)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      hist[ch] = {};
      samp[ch] = {};
      // Synchronizer flops come out of reset holding zeros.
      for (int i = 0; i < S; i++) hist[ch].push_back(1'b0);
      lvl[ch] = 1'b0;
    end
    c_db_m = 1'b0;
    rise_m = 0;
  endfunction

  function automatic void model_edge();
    bit new_c;
    new_c = lvl[0] | lvl[1];
    for (int ch = 0; ch < 2; ch++) begin
      bit x;
      bit s;
      bit all_diff;
      x = (ch == 0) ? a : b;
      hist[ch].push_back(x);
      // The value entering the debouncer now was captured S edges ago.
      s = hist[ch][hist[ch].size() - 1 - S];
      samp[ch].push_back(s);
      if (hist[ch].size() > 16) void'(hist[ch].pop_front());
      if (samp[ch].size() > 16) void'(samp[ch].pop_front());
      if (samp[ch].size() >= D) begin
        all_diff = 1'b1;
        for (int i = 0; i < D; i++)
          if (samp[ch][samp[ch].size() - 1 - i] == lvl[ch]) all_diff = 1'b0;
        if (all_diff) lvl[ch] = ~lvl[ch];
      end
    end
    if (new_c && !c_db_m) rise_m++;
    c_db_m = new_c;
  endfunction

  task automatic check_all(input string tag);
    check({tag, " c"},         c,         a | b);
    check({tag, " a_db"},      a_db,      lvl[0]);
    check({tag, " b_db"},      b_db,      lvl[1]);
    check({tag, " c_db"},      c_db,      c_db_m);
    check({tag, " rise_cnt"},  rise_cnt,  32'(rise_m % 256));
    check({tag, " a_db2"},     a_db2,     lvl[0]);
    check({tag, " b_db2"},     b_db2,     lvl[1]);
    check({tag, " c_db2"},     c_db2,     c_db_m);
    check({tag, " rise_cnt2"}, rise_cnt2, 32'(rise_m % 4));
  endtask

  // One clock: update the model at the edge, compare 1 time unit later.
  // Inputs are changed by the caller only after this returns.
  task automatic step(input string tag);
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic hold(input int n, input string tag);
    repeat (n) step(tag);
  endtask

  task automatic apply_reset(input string tag);
    rst = 1'b1;
    model_reset();
    #1;
    check_all(tag);
  endtask

  initial begin
    int wrap_exp[5];
    wrap_exp = '{1, 2, 3, 0, 1};

    // Combinational truth table with the clock idle and reset held.
    rst = 1'b1; a = 1'b0; b = 1'b0;
    model_reset();
    #1; check("tt00 c", c, 1'b0); check_all("reset");
    #4; a = 1'b0; b = 1'b1;
    #1; check("tt01 c", c, 1'b1);
    #4; a = 1'b1; b = 1'b0;
    #1; check("tt10 c", c, 1'b1);
    #4; a = 1'b1; b = 1'b1;
    #1; check("tt11 c", c, 1'b1);

    a = 1'b0; b = 1'b0;
    clk_en = 1'b1;
    hold(3, "in_reset");

    // Debounce latency: a_db exactly 6 clocks after the first capturing edge.
    rst = 1'b0; a = 1'b1; b = 1'b0;
    hold(5, "lat_pre");
    check("lat a_db before 6", a_db, 1'b0);
    step("lat6");
    check("lat a_db at 6", a_db, 1'b1);
    check("lat c_db at 6", c_db, 1'b0);
    step("lat7");
    check("lat c_db at 7", c_db, 1'b1);
    check("lat rise_cnt", rise_cnt, 8'd1);
    check("lat b_db", b_db, 1'b0);

    // Overlap: b joins, then a leaves; c_db never drops and counts once.
    b = 1'b1;
    for (int i = 0; i < 8; i++) begin step("ovl_b"); check("ovl c_db hi", c_db, 1'b1); end
    a = 1'b0;
    for (int i = 0; i < 8; i++) begin step("ovl_a"); check("ovl c_db hi", c_db, 1'b1); end
    check("ovl a_db", a_db, 1'b0);
    check("ovl rise_cnt", rise_cnt, 8'd1);
    b = 1'b0;
    hold(8, "ovl_fall");
    check("fall c_db", c_db, 1'b0);

    // Glitch: 3-clock pulse on b is visible on c but filtered out of b_db.
    b = 1'b1;
    for (int i = 0; i < 3; i++) begin step("glitch"); check("glitch c", c, 1'b1); end
    b = 1'b0;
    hold(10, "glitch_after");
    check("glitch b_db", b_db, 1'b0);
    check("glitch c_db", c_db, 1'b0);
    check("glitch rise_cnt", rise_cnt, 8'd1);

    // Four more rising edges, ending with a_db high and rise_cnt = 5.
    for (int e = 2; e <= 5; e++) begin
      a = 1'b1;
      hold(8, "edges_hi");
      check("edges rise_cnt", rise_cnt, 32'(e));
      if (e < 5) begin
        a = 1'b0;
        hold(8, "edges_lo");
      end
    end
    check("pre_rst a_db", a_db, 1'b1);

    // Asynchronous reset between edges.
    #2;
    apply_reset("async_rst");
    check("arst a_db", a_db, 1'b0);
    check("arst c_db", c_db, 1'b0);
    check("arst rise_cnt", rise_cnt, 8'd0);
    check("arst c", c, 1'b1);
    hold(2, "arst_hold");
    rst = 1'b0;

    // Wrap on the CNT_W=2 instance: a is still high and requalifies first.
    for (int e = 0; e < 5; e++) begin
      if (e > 0) begin
        a = 1'b0;
        hold(8, "wrap_lo");
        a = 1'b1;
      end
      hold(8, "wrap_hi");
      check("wrap rise_cnt2", rise_cnt2, 32'(wrap_exp[e]));
      check("wrap rise_cnt", rise_cnt, 32'(e + 1));
    end

    // Random switch activity with occasional mid-cycle resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) a = ~a;
      if ($urandom_range(0, 7) == 0) b = ~b;
      if ($urandom_range(0, 99) == 0) begin
        apply_reset("rand_rst");
        step("rand_rst_hold");
        rst = 1'b0;
      end
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_or_gate
